pipeline_stall_ctrl: RTL
========================

# pipeline_stall_ctrl

Central stall/flush scheduler for the 5-stage pipeline. It combines register-dependency checking (ID against EXE/MEM), branch-redirect flushing and data-memory wait handling into one consistent set of freeze, bubble and flush controls. It sits beside the ID stage and drives the IF/ID, ID/EXE and EXE/MEM pipeline-register enables and the control-unit `hazard_detected` input. It replaces ad-hoc per-stage stall logic.

## Interface
- `MEM_TIMEOUT`, 64: maximum consecutive MEM_WAIT cycles before a fatal error.
- `CNT_W`, 16: width of the stall-cycle counter.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `forward_EN` in 1: 1 means the forwarding unit is active, so only load-use dependencies stall.
- `src1_ID`, `src2_ID` in `REG_FILE_ADDR_LEN`: ID-stage source registers.
- `is_imm`, `ST_or_BNE` in 1: `src2_ID` is live when `!is_imm || ST_or_BNE`.
- `dest_EXE` in `REG_FILE_ADDR_LEN`; `WB_EN_EXE`, `MEM_R_EN_EXE` in 1: EXE-stage writer info.
- `dest_MEM` in `REG_FILE_ADDR_LEN`; `WB_EN_MEM` in 1: MEM-stage writer info.
- `branch_taken_ID` in 1: branch or jump resolved taken in ID.
- `mem_req_MEM` in 1: MEM stage is issuing a load or store this cycle.
- `mem_ready` in 1: data memory completes the access this cycle.
- `hazard_detected` out 1: freeze PC and IF/ID, and insert a bubble into ID/EXE.
- `flush_IF_ID` out 1: squash the IF/ID instruction.
- `freeze_all` out 1: hold every pipeline register and the PC.
- `mem_timeout` out 1: sticky fatal error flag.
- `stall_cnt` out `CNT_W`: saturating count of stalled cycles.

## Operation
- **Raw dependency** (combinational):
  - `m1E = (src1_ID==dest_EXE) && WB_EN_EXE`.
  - `m2E` is the same test for `src2_ID` and is additionally gated by src2-live.
  - `m1M` and `m2M` are the same two tests against `dest_MEM` / `WB_EN_MEM`.
  - A destination of register 0 never matches.
  - When `forward_EN==0`: `raw = m1E|m2E|m1M|m2M`.
  - When `forward_EN==1`: `raw = (m1E|m2E) && MEM_R_EN_EXE`, i.e. load-use only.
- **Output priority**, highest first: `freeze_all`, then `hazard_detected`, then `flush_IF_ID`.
  - `hazard_detected = raw && !freeze_all`.
  - `flush_IF_ID = branch_taken_ID && !raw && !freeze_all`. A taken branch with unready operands is not honoured; it re-resolves after the stall.
- **FSM** states are RUN, MEM_WAIT and ERROR.
  - RUN:
    - `freeze_all = mem_req_MEM && !mem_ready`.
    - If that is true, go to MEM_WAIT with `wait_cnt <= 1`.
  - MEM_WAIT:
    - `freeze_all = !mem_ready`.
    - `mem_ready` returns the FSM to RUN with `wait_cnt <= 0`.
    - Otherwise `wait_cnt` increments.
    - When `wait_cnt == MEM_TIMEOUT` with `mem_ready` still low, go to ERROR.
  - ERROR: `freeze_all = 1` and `mem_timeout = 1`. The state is left only by `rst`.
- **`stall_cnt`**: increments on each cycle where `hazard_detected || freeze_all`, and saturates at all-ones.

## Timing
- `hazard_detected`, `flush_IF_ID` and `freeze_all` are combinational from the current inputs and registered state, with zero latency. No output feeds back into these inputs within the block.
- State, `wait_cnt`, `stall_cnt` and `mem_timeout` update on the rising `clk` edge.
- Reset values: state RUN, `wait_cnt` 0, `stall_cnt` 0, `mem_timeout` 0.
- While `rst` is high, all outputs are forced to 0.
- Reset asserted in MEM_WAIT or ERROR returns the FSM to RUN on the next edge, discarding the wait.
- `mem_ready` arriving in the same cycle as the request (RUN) causes no freeze and no state change.
- `mem_ready` arriving on exactly the `MEM_TIMEOUT` cycle counts as success: the FSM returns to RUN and does not enter ERROR.
- A hazard that coincides with `freeze_all` produces no bubble. It is re-evaluated once the freeze clears.

## Structure
- Package `pipe_ctrl_pkg` holds:
  - the state enum `stall_state_e` {RUN, MEM_WAIT, ERROR};
  - the default `MEM_TIMEOUT`;
  - a `let`/function for src2-live.
- Width macros come from `defines.v`.
- Sub-module `raw_dep_cmp` is purely combinational. It takes the sources, destinations, enables and `forward_EN`, and outputs `raw`.
- The top level holds the FSM and the counters.

## Test plan
- `forward_EN=0`, `src1_ID=3`, `dest_EXE=3`, `WB_EN_EXE=1` -> `hazard_detected=1`, `flush_IF_ID=0`, and `stall_cnt` increments by 1.
- `forward_EN=1`, `src2_ID=5`, `is_imm=0`, `dest_EXE=5`, `WB_EN_EXE=1`, `MEM_R_EN_EXE=0` -> `hazard_detected=0`. Next cycle with `MEM_R_EN_EXE=1` -> `hazard_detected=1`.
- `is_imm=1`, `ST_or_BNE=0`, `src2_ID=dest_MEM=7`, `WB_EN_MEM=1`, `forward_EN=0` -> `hazard_detected=0`. Also, `dest_EXE=0` with `src1_ID=0` -> no hazard.
- `branch_taken_ID=1` without a hazard -> `flush_IF_ID=1`. The same input with `src1_ID` matching `dest_EXE` -> `flush_IF_ID=0` and `hazard_detected=1`.
- `mem_req_MEM=1`, `mem_ready` low for 3 cycles and then high -> `freeze_all=1` for 3 cycles, FSM back in RUN, `stall_cnt=3`.
- `mem_ready` held low for 70 cycles with `MEM_TIMEOUT=64`:
  - `mem_timeout=1` after 64 wait cycles, with `freeze_all` held high.
  - `rst` pulse -> all outputs 0 and the FSM in RUN.

Source files
------------

// File: rtl/pipeline_stall_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush scheduler.
//   stall_state_e     : scheduler FSM states
//   REG_FILE_ADDR_LEN : register-file address width (mirrors the core's defines.v)
//   MEM_TIMEOUT_DEF   : default max consecutive MEM_WAIT cycles
//   CNT_W_DEF         : default stall counter width
//   src2_live()       : ID src2 is a real register read
package pipe_ctrl_pkg;
  localparam int REG_FILE_ADDR_LEN = 5;
  localparam int MEM_TIMEOUT_DEF   = 64;
  localparam int CNT_W_DEF         = 16;

  typedef enum logic [1:0] {RUN, MEM_WAIT, ERROR} stall_state_e;

  // Immediates replace src2, except stores/BNE which still read it.
  function automatic logic src2_live(input logic is_imm, input logic st_or_bne);
    return !is_imm || st_or_bne;
  endfunction
endpackage

// File: rtl/pipeline_stall_ctrl_if.sv
// Bundle between the pipeline datapath (master) and the stall scheduler (slave).
//   master drives ID sources, EXE/MEM writer info, branch and memory handshake;
//   slave drives hazard_detected, flush_IF_ID, freeze_all, mem_timeout, stall_cnt.
interface pipeline_stall_ctrl_if #(parameter int CNT_W = 16);
  localparam int AW = pipe_ctrl_pkg::REG_FILE_ADDR_LEN;

  logic          forward_EN;
  logic [AW-1:0] src1_ID, src2_ID;
  logic          is_imm, ST_or_BNE;
  logic [AW-1:0] dest_EXE;
  logic          WB_EN_EXE, MEM_R_EN_EXE;
  logic [AW-1:0] dest_MEM;
  logic          WB_EN_MEM;
  logic          branch_taken_ID;
  logic          mem_req_MEM, mem_ready;
  logic          hazard_detected, flush_IF_ID, freeze_all, mem_timeout;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output forward_EN, src1_ID, src2_ID, is_imm, ST_or_BNE, dest_EXE, WB_EN_EXE,
           MEM_R_EN_EXE, dest_MEM, WB_EN_MEM, branch_taken_ID, mem_req_MEM, mem_ready,
    input  hazard_detected, flush_IF_ID, freeze_all, mem_timeout, stall_cnt
  );

  modport slave (
    input  forward_EN, src1_ID, src2_ID, is_imm, ST_or_BNE, dest_EXE, WB_EN_EXE,
           MEM_R_EN_EXE, dest_MEM, WB_EN_MEM, branch_taken_ID, mem_req_MEM, mem_ready,
    output hazard_detected, flush_IF_ID, freeze_all, mem_timeout, stall_cnt
  );
endinterface

// File: rtl/pipeline_stall_ctrl_raw_dep_cmp.sv
// Combinational RAW dependency check of ID sources against EXE/MEM writers.
//   i_forward_en  : forwarding active -> only load-use in EXE stalls
//   i_src1/i_src2 : ID sources, i_src2_live qualifies i_src2
//   i_dest_*, i_wb_en_*, i_mem_r_en_exe : writer info
//   o_raw         : dependency requires a stall
module raw_dep_cmp
  import pipe_ctrl_pkg::*;
(
  input  logic                         i_forward_en,
  input  logic [REG_FILE_ADDR_LEN-1:0] i_src1,
  input  logic [REG_FILE_ADDR_LEN-1:0] i_src2,
  input  logic                         i_src2_live,
  input  logic [REG_FILE_ADDR_LEN-1:0] i_dest_exe,
  input  logic                         i_wb_en_exe,
  input  logic                         i_mem_r_en_exe,
  input  logic [REG_FILE_ADDR_LEN-1:0] i_dest_mem,
  input  logic                         i_wb_en_mem,
  output logic                         o_raw
);
  logic w_exe_wr, w_mem_wr;
  logic w_m1e, w_m2e, w_m1m, w_m2m;

  // r0 is hardwired zero, so a write to it is never a real producer.
  assign w_exe_wr = i_wb_en_exe && (i_dest_exe != '0);
  assign w_mem_wr = i_wb_en_mem && (i_dest_mem != '0);

  assign w_m1e = w_exe_wr && (i_src1 == i_dest_exe);
  assign w_m2e = w_exe_wr && (i_src2 == i_dest_exe) && i_src2_live;
  assign w_m1m = w_mem_wr && (i_src1 == i_dest_mem);
  assign w_m2m = w_mem_wr && (i_src2 == i_dest_mem) && i_src2_live;

  assign o_raw = i_forward_en ? ((w_m1e || w_m2e) && i_mem_r_en_exe)
                              : (w_m1e || w_m2e || w_m1m || w_m2m);
endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Central stall/flush scheduler for the 5-stage pipeline.
//   clk, rst : rising-edge clock, synchronous active-high reset
//   bus      : slave side of pipeline_stall_ctrl_if (dependency inputs, branch,
//              memory handshake in; hazard/flush/freeze, timeout flag, stall count out)
// Priority: freeze_all > hazard_detected > flush_IF_ID.
module pipeline_stall_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  pipeline_stall_ctrl_if.slave  bus
);
  localparam int WC_W = $clog2(MEM_TIMEOUT + 1);

  stall_state_e     r_state, w_state_nxt;
  logic [WC_W-1:0]  r_wait_cnt, w_wait_cnt_nxt;
  logic [CNT_W-1:0] r_stall_cnt;
  logic             r_mem_timeout;
  logic             w_raw, w_freeze, w_hazard, w_flush;

  raw_dep_cmp u_raw (
    .i_forward_en   (bus.forward_EN),
    .i_src1         (bus.src1_ID),
    .i_src2         (bus.src2_ID),
    .i_src2_live    (src2_live(bus.is_imm, bus.ST_or_BNE)),
    .i_dest_exe     (bus.dest_EXE),
    .i_wb_en_exe    (bus.WB_EN_EXE),
    .i_mem_r_en_exe (bus.MEM_R_EN_EXE),
    .i_dest_mem     (bus.dest_MEM),
    .i_wb_en_mem    (bus.WB_EN_MEM),
    .o_raw          (w_raw)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= RUN;
      r_wait_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_cnt_nxt;
    end
  end

  // wait_cnt numbers the MEM_WAIT cycles (1..MEM_TIMEOUT); ready on the last
  // one still succeeds, only a miss there is fatal.
  always_comb begin
    w_state_nxt    = r_state;
    w_wait_cnt_nxt = r_wait_cnt;
    w_freeze       = 1'b0;
    case (r_state)
      RUN: begin
        if (bus.mem_req_MEM && !bus.mem_ready) begin
          w_freeze       = 1'b1;
          w_state_nxt    = MEM_WAIT;
          w_wait_cnt_nxt = WC_W'(1);
        end
      end
      MEM_WAIT: begin
        if (bus.mem_ready) begin
          w_state_nxt    = RUN;
          w_wait_cnt_nxt = '0;
        end else begin
          w_freeze = 1'b1;
          if (r_wait_cnt == WC_W'(MEM_TIMEOUT)) w_state_nxt = ERROR;
          else                                  w_wait_cnt_nxt = r_wait_cnt + WC_W'(1);
        end
      end
      ERROR:   w_freeze    = 1'b1;
      default: w_state_nxt = RUN;
    endcase
  end

  // A stalled branch is dropped here and re-resolves once operands are ready.
  assign w_hazard = w_raw && !w_freeze && !rst;
  assign w_flush  = bus.branch_taken_ID && !w_raw && !w_freeze && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt   <= '0;
      r_mem_timeout <= 1'b0;
    end else begin
      if ((w_hazard || w_freeze) && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (w_state_nxt == ERROR)
        r_mem_timeout <= 1'b1;
    end
  end

  assign bus.hazard_detected = w_hazard;
  assign bus.flush_IF_ID     = w_flush;
  assign bus.freeze_all      = w_freeze && !rst;
  assign bus.mem_timeout     = r_mem_timeout && !rst;
  assign bus.stall_cnt       = rst ? '0 : r_stall_cnt;
endmodule
